// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM state
// encoding, the dark segment pattern and the hex glyph table.
// Glyphs are active-low in {A,B,C,D,E,F,G} order.
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] GLYPH [16] = '{
      7'b0000001,   // 0
      7'b1001111,   // 1
      7'b0010010,   // 2
      7'b0000110,   // 3
      7'b1001100,   // 4
      7'b0100100,   // 5
      7'b0100000,   // 6
      7'b0001111,   // 7
      7'b0000000,   // 8
      7'b0000100,   // 9
      7'b0001000,   // A
      7'b1100000,   // b
      7'b0110001,   // C
      7'b1000010,   // d
      7'b0110000,   // E
      7'b0111000    // F
   };

endpackage

// File: rtl/hex7_dec.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module hex7_dec
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   // Straight table lookup; every nibble value has a glyph.
   always_comb begin
      seg = GLYPH[nib];
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for N common-anode 7-segment digits.
// A pending register bank captures DATA/DP_IN on LOAD; a shadow bank is
// refreshed from it only at the start of a frame (entry to BLANK for
// digit 0), so a frame never mixes old and new values. Each digit slot is
// BLANK_CYC cycles with all anodes off followed by SCAN_DIV cycles lit.
// All pin outputs are registered and follow the FSM by one cycle.
//
// Build option: SEG_SCAN_LZ_BLANK_EN enables leading-zero suppression
// (digit k>0 is dark when it and all higher digits hold 0; its DP still
// follows the request). Without it every digit shows its glyph.
//
// Handshake: LOAD is a bare strobe with no ready; it is accepted on
// every cycle RST is low and always overwrites the pending bank.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500
)
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic                  LOAD,
   input  logic [4*N_DIGITS-1:0] DATA,
   input  logic [N_DIGITS-1:0]   DP_IN,
   output logic [6:0]            SEG_N,
   output logic                  DP_N,
   output logic [N_DIGITS-1:0]   AN_N,
   output logic                  FRAME,
   output state_t                dbg_state
);

   // SCAN_DIV > BLANK_CYC, so one counter width covers both phases.
   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = $clog2(N_DIGITS);

   localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0]    DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] AN_ONE     = N_DIGITS'(1);

   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         wrap;
   logic                         shadow_load;

   logic [4*N_DIGITS-1:0]        pend_data_q;
   logic [N_DIGITS-1:0]          pend_dp_q;
   logic [N_DIGITS-1:0][3:0]     shad_data_q;
   logic [N_DIGITS-1:0]          shad_dp_q;

   logic [3:0]                   cur_nib;
   logic [6:0]                   cur_glyph;
   logic                         suppress;

   assign dbg_state = state_q;

   // FSM state, digit index and prescaler registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; EN low from any state parks in IDLE with index and
   // prescaler cleared, so re-enabling always restarts at digit 0.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      wrap        = 1'b0;
      shadow_load = 1'b0;
      if (!EN) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d     = BLANK;
               idx_d       = '0;
               cnt_d       = '0;
               shadow_load = 1'b1;
            end
            BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = DRIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DRIVE: begin
               if (cnt_q == DRIVE_LAST) begin
                  state_d = BLANK;
                  cnt_d   = '0;
                  if (idx_q == IDX_LAST) begin
                     idx_d       = '0;
                     wrap        = 1'b1;
                     shadow_load = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Pending bank takes LOAD; shadow bank takes the pre-edge pending value
   // at frame start, so a LOAD on that same edge lands in the next frame.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_data_q <= '0;
         pend_dp_q   <= '0;
         shad_data_q <= '0;
         shad_dp_q   <= '0;
      end else begin
         if (LOAD) begin
            pend_data_q <= DATA;
            pend_dp_q   <= DP_IN;
         end
         if (shadow_load) begin
            shad_data_q <= pend_data_q;
            shad_dp_q   <= pend_dp_q;
         end
      end
   end

   assign cur_nib = shad_data_q[idx_q];

   hex7_dec u_dec (
      .nib (cur_nib),
      .seg (cur_glyph)
   );

`ifdef SEG_SCAN_LZ_BLANK_EN
   logic [N_DIGITS-1:0] lz_mask;
   logic                zero_run;

   // A digit is a leading zero when it and every higher digit are zero;
   // digit 0 is never masked.
   always_comb begin
      lz_mask  = '0;
      zero_run = 1'b1;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         zero_run   = zero_run & (shad_data_q[k] == 4'd0);
         lz_mask[k] = zero_run;
      end
   end

   assign suppress = lz_mask[idx_q];
`else
   assign suppress = 1'b0;
`endif

   // Registered pin drivers: lit only while DRIVE, dark otherwise.
   always_ff @(posedge CLK) begin
      if (RST) begin
         SEG_N <= SEG_OFF;
         DP_N  <= 1'b1;
         AN_N  <= '1;
         FRAME <= 1'b0;
      end else begin
         FRAME <= wrap;
         if (state_q == DRIVE) begin
            SEG_N <= suppress ? SEG_OFF : cur_glyph;
            DP_N  <= ~shad_dp_q[idx_q];
            AN_N  <= ~(AN_ONE << idx_q);
         end else begin
            SEG_N <= SEG_OFF;
            DP_N  <= 1'b1;
            AN_N  <= '1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with small scan parameters. A behavioural model
// derives expected pins from the elapsed scan time since enable; a compare
// process checks every cycle, and directed sequences pin literal glyphs.
module tb_seg_scan_ctrl;

   localparam int N  = 4;
   localparam int S  = 8;
   localparam int B  = 2;
   localparam int DIG_LEN   = B + S;
   localparam int FRAME_LEN = N * DIG_LEN;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            en = 1'b0;
   logic            load = 1'b0;
   logic [4*N-1:0]  data = '0;
   logic [N-1:0]    dp_in = '0;
   logic [6:0]      seg_n;
   logic            dp_n;
   logic [N-1:0]    an_n;
   logic            frame;
   seg_pkg::state_t dbg_state;

   int tests = 0;
   int fails = 0;

   logic [6:0] glyph_tb [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   seg_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(S), .BLANK_CYC(B)) dut (
      .CLK       (clk),
      .RST       (rst),
      .EN        (en),
      .LOAD      (load),
      .DATA      (data),
      .DP_IN     (dp_in),
      .SEG_N     (seg_n),
      .DP_N      (dp_n),
      .AN_N      (an_n),
      .FRAME     (frame),
      .dbg_state (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic           running = 1'b0;
   int             pos = 0;
   logic [4*N-1:0] m_pend = '0;
   logic [N-1:0]   m_pdp = '0;
   logic [4*N-1:0] m_shad = '0;
   logic [N-1:0]   m_sdp = '0;
   logic [6:0]     exp_seg = 7'h7F;
   logic           exp_dp = 1'b1;
   logic [N-1:0]   exp_an = '1;
   logic           exp_frame = 1'b0;

   function automatic logic [6:0] exp_glyph(input logic [4*N-1:0] sh, input int d);
      logic [4*N-1:0] t;
      logic [3:0]     v;
      t = sh >> (4 * d);
      v = t[3:0];
`ifdef SEG_SCAN_LZ_BLANK_EN
      if (d > 0 && t == '0) return 7'h7F;
`endif
      return glyph_tb[v];
   endfunction

   // Expected pins after each edge follow from where the scan stood before it.
   always @(posedge clk) begin
      int ph, dig;
      if (rst) begin
         exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = '1; exp_frame = 1'b0;
         running = 1'b0; pos = 0;
         m_pend = '0; m_pdp = '0; m_shad = '0; m_sdp = '0;
      end else begin
         exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = '1;
         if (running) begin
            ph  = pos % DIG_LEN;
            dig = (pos / DIG_LEN) % N;
            if (ph >= B) begin
               exp_an  = ~(N'(1) << dig);
               exp_seg = exp_glyph(m_shad, dig);
               exp_dp  = ~m_sdp[dig];
            end
         end
         exp_frame = running && en && ((pos % FRAME_LEN) == FRAME_LEN - 1);
         if (!en) begin
            running = 1'b0; pos = 0;
         end else if (!running) begin
            running = 1'b1; pos = 0;
            m_shad = m_pend; m_sdp = m_pdp;
         end else begin
            pos++;
            if (pos % FRAME_LEN == 0) begin
               m_shad = m_pend; m_sdp = m_pdp;
            end
         end
         if (load) begin
            m_pend = data; m_pdp = dp_in;
         end
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   always @(negedge clk) begin
      chk("seg_n", 32'(seg_n), 32'(exp_seg));
      chk("dp_n", 32'(dp_n), 32'(exp_dp));
      chk("an_n", 32'(an_n), 32'(exp_an));
      chk("frame", 32'(frame), 32'(exp_frame));
      chk("an_onehot", 32'($countones(~an_n) <= 1), 32'd1);
   end

   // ---------------- driver tasks ----------------
   task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] p);
      data = d; dp_in = p; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_an(input logic [N-1:0] pat, input string nm);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (an_n == pat) return;
      end
      chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_frame(input string nm);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (frame) return;
      end
      chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      rst = 1'b1; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_seg", 32'(seg_n), 32'h7F);
         chk("rst_an", 32'(an_n), 32'hF);
         chk("rst_dp", 32'(dp_n), 32'd1);
         chk("rst_frame", 32'(frame), 32'd0);
         chk("rst_state", 32'(dbg_state), 32'(seg_pkg::IDLE));
      end
      rst = 1'b0;
      do_load(16'h1234, 4'b0100);

      // two frames so the 1234 load is surely in the shadow
      wait_frame("f1"); wait_frame("f2");
      wait_an(4'b1110, "d0");
      chk("pin_d0_seg", 32'(seg_n), 32'b1001100);
      chk("pin_d0_dp", 32'(dp_n), 32'd1);
      wait_an(4'b1101, "d1");
      chk("pin_d1_seg", 32'(seg_n), 32'b0000110);
      wait_an(4'b1011, "d2");
      chk("pin_d2_seg", 32'(seg_n), 32'b0010010);
      chk("pin_d2_dp", 32'(dp_n), 32'd0);
      wait_an(4'b0111, "d3");
      chk("pin_d3_seg", 32'(seg_n), 32'b1001111);

      // mid-frame load keeps the current frame intact
      wait_frame("f3");
      wait_an(4'b1101, "m1");
      do_load(16'hAAAA, 4'b0000);
      wait_an(4'b0111, "m3");
      chk("pin_old_frame", 32'(seg_n), 32'b1001111);
      wait_frame("f4");
      wait_an(4'b1110, "a0");
      chk("pin_aaaa_d0", 32'(seg_n), 32'b0001000);
      wait_an(4'b0111, "a3");
      chk("pin_aaaa_d3", 32'(seg_n), 32'b0001000);

      // EN drop during digit 2, then restart
      wait_an(4'b1011, "e2");
      en = 1'b0;
      @(negedge clk);
      chk("pin_en_drop_still", 32'(an_n), 32'b1011);
      @(negedge clk);
      chk("pin_en_drop_dark", 32'(an_n), 32'hF);
      repeat (3) @(negedge clk);
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("pin_restart_dark", 32'(an_n), 32'hF);
      end
      @(negedge clk);
      chk("pin_restart_d0", 32'(an_n), 32'b1110);

      // leading-zero handling
      do_load(16'h0050, 4'b0000);
      wait_frame("f5"); wait_frame("f6");
      wait_an(4'b1110, "z0");
      chk("pin_lz_d0", 32'(seg_n), 32'b0000001);
      wait_an(4'b1101, "z1");
      chk("pin_lz_d1", 32'(seg_n), 32'b0100100);
      wait_an(4'b1011, "z2");
`ifdef SEG_SCAN_LZ_BLANK_EN
      chk("pin_lz_d2", 32'(seg_n), 32'h7F);
`else
      chk("pin_lz_d2", 32'(seg_n), 32'b0000001);
`endif
      do_load(16'h0000, 4'b0000);
      wait_frame("f7"); wait_frame("f8");
      wait_an(4'b1110, "y0");
      chk("pin_zero_d0", 32'(seg_n), 32'b0000001);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         load  = ($urandom_range(0, 11) == 0);
         data  = 16'($urandom);
         dp_in = 4'($urandom);
         en    = ($urandom_range(0, 299) != 0);
         rst   = ($urandom_range(0, 999) == 0);
         @(negedge clk);
      end
      load = 1'b0; rst = 1'b0; en = 1'b1;

      // frame cadence under continuous scanning
      for (int r = 0; r < 3; r++) begin
         int n;
         wait_frame("fp");
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!frame && n < 100);
         chk("frame_period", 32'(n), 32'(FRAME_LEN));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one segment bus. It holds a shadow copy of N 4-bit hex values plus decimal points and steps through the digits one at a time, driving the shared hex decoder and enabling one digit's anode per slot. A blanking gap between digits prevents ghosting. It sits between the switch/register logic that produces the values and the board's segment and anode pins.

## Interface
- N_DIGITS, 4, number of multiplexed digits (2..8)
- SCAN_DIV, 50000, CLK cycles each digit is driven (≥ 4)
- BLANK_CYC, 500, CLK cycles with all anodes off before each digit (≥ 1, < SCAN_DIV)
- CLK  in  1  system clock; all logic on the rising edge
- RST  in  1  synchronous, active-high reset
- EN  in  1  scan enable; 0 forces the display dark
- LOAD  in  1  single-cycle strobe that captures DATA and DP_IN into the pending registers
- DATA  in  4*N_DIGITS  hex values; digit k is DATA[4k+3:4k], digit 0 is rightmost
- DP_IN  in  N_DIGITS  decimal point request per digit, 1 = lit
- SEG_N  out  7  segments {A,B,C,D,E,F,G}, active-low
- DP_N  out  1  decimal point, active-low
- AN_N  out  N_DIGITS  digit anode enables, active-low, at most one low at a time
- FRAME  out  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to digit 0

## Operation
- Reset: state IDLE, digit index 0, prescaler 0, pending and shadow registers 0; SEG_N=7'h7F, DP_N=1, AN_N all 1, FRAME=0.
- FSM states:
  - IDLE: all outputs dark. When EN=1, go to BLANK with index 0.
  - BLANK: all anodes off for BLANK_CYC cycles, then go to DRIVE.
  - DRIVE: AN_N[index]=0 for SCAN_DIV cycles, then go to BLANK with index+1.
- Index wraps from N_DIGITS-1 to 0. FRAME pulses on that wrap.
- EN=0 in any state goes to IDLE on the next edge, resets index and prescaler, and forces outputs dark one cycle later.
- LOAD writes the pending registers. The shadow registers copy pending on entry to BLANK for index 0, so a frame never mixes old and new data.
- LOAD in the same cycle as the shadow copy: the shadow takes the value pending held before that edge; the new value is used in the next frame.
- Decoding uses standard hex glyphs, active-low: 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100, A→0001000, b→1100000, C→0110001, d→1000010, E→0110000, F→0111000.
- During BLANK and IDLE, SEG_N=7'h7F and DP_N=1.

## Timing
- All outputs are registered. SEG_N, DP_N and AN_N change on the same edge, one cycle after the FSM state or index changes.
- Steady state: each digit period is BLANK_CYC+SCAN_DIV cycles; a frame is N_DIGITS times that.
- After EN rises: first anode goes low BLANK_CYC+1 cycles later.
- LOAD to visible: at most one frame plus BLANK_CYC+1 cycles.
- RST asserted in the middle of a scan takes effect on the next edge and returns everything to reset values, including pending data.

## Configuration
- SEG_SCAN_LZ_BLANK_EN defined: leading-zero suppression. Digit k>0 shows SEG_N=7'h7F when its shadow value and every higher digit's value are 0. Its anode still scans and its DP still follows DP_IN. Digit 0 is never suppressed.
- Not defined: every digit shows its glyph.

## Structure
- Shared package seg_pkg holds:
  - the 16-entry glyph constant array
  - the FSM state enum (IDLE, BLANK, DRIVE)
  - SEG_OFF = 7'h7F
- Sub-module hex7_dec: purely combinational nibble-to-SEG_N lookup using seg_pkg; seg_scan_ctrl instantiates it once.
- The prescaler and FSM live in seg_scan_ctrl.

## Test plan
All cases use small parameters (SCAN_DIV=8, BLANK_CYC=2).
- RST held for 3 cycles, EN=1 → SEG_N=7F, AN_N=F, DP_N=1, FRAME=0 throughout reset.
- LOAD DATA=16'h1234, DP_IN=4'b0100 → per digit: AN_N=1110 with SEG_N=1001100 (4), then 1101 with 0000110 (3), then 1011 with 0010010 (2) and DP_N=0, then 0111 with 1001111 (1). Each digit lasts 8 cycles and is preceded by 2 cycles of AN_N=F.
- LOAD 16'hAAAA in the middle of a frame → the current frame keeps the old glyphs; the next frame shows 0001000 on all digits.
- EN dropped during DRIVE of digit 2 → AN_N=F on the next-but-one edge; re-asserting EN restarts at digit 0 after 3 cycles.
- With SEG_SCAN_LZ_BLANK_EN defined, DATA=16'h0050 → digits 3 and 2 show 7F, digit 1 shows 0100100, digit 0 shows 0000001. With DATA=0, digit 0 still shows 0000001.
- Across continuous scanning, FRAME pulses exactly once per 40 cycles, and AN_N never has more than one bit low.
